// File: rtl/jtopl_snd_pkg.sv
// Shared constants for the jtopl sound path: default widths, the drop counter
// width and the saturation limits also used by the accumulator.
package jtopl_snd_pkg;

  localparam int OUTW_DEF  = 16;
  localparam int DEPTH_DEF = 4;
  localparam int DCK_DEF   = 8;
  localparam int DROPW     = 8;

  localparam logic signed [OUTW_DEF-1:0] PLUS_INF  = 16'sh7FFF;
  localparam logic signed [OUTW_DEF-1:0] MINUS_INF = 16'sh8000;

endpackage

// File: rtl/jtopl_snd_fifo_if.sv
// Sample handshake between the sound FIFO (master) and the mixer/DAC (slave).
interface jtopl_snd_fifo_if
  import jtopl_snd_pkg::*;
#(
  parameter int OUTW = OUTW_DEF
);

  logic signed [OUTW-1:0] dout;
  logic                   dout_valid;
  logic                   dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/jtopl_snd_dcblk.sv
// One-pole DC blocker y = x - x_prev + y_prev - (y_prev >>> DCK), saturated to OUTW.
// Output is combinational; filter state advances only when cap_i is high.
module jtopl_snd_dcblk
  import jtopl_snd_pkg::*;
#(
  parameter int OUTW = OUTW_DEF,
  parameter int DCK  = DCK_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap_i,
  input  logic signed [OUTW-1:0] x_i,
  output logic signed [OUTW-1:0] y_o
);

  localparam int W = OUTW + 2;
  localparam logic signed [W-1:0] Y_MAX = W'({1'b0, {(OUTW-1){1'b1}}});
  localparam logic signed [W-1:0] Y_MIN = ~Y_MAX;

  logic signed [OUTW-1:0] xp_q, yp_q;
  logic signed [W-1:0]    x_e, xp_e, yp_e, sum;

  assign x_e  = {{2{x_i[OUTW-1]}}, x_i};
  assign xp_e = {{2{xp_q[OUTW-1]}}, xp_q};
  assign yp_e = {{2{yp_q[OUTW-1]}}, yp_q};

  // Two guard bits hold the worst case |x - x_prev| + |y_prev| without wrap.
  assign sum = x_e - xp_e + yp_e - (yp_e >>> DCK);

  always_comb begin
    y_o = sum[OUTW-1:0];
    if (sum > Y_MAX) begin
      y_o = Y_MAX[OUTW-1:0];
    end else if (sum < Y_MIN) begin
      y_o = Y_MIN[OUTW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xp_q <= '0;
      yp_q <= '0;
    end else if (cap_i) begin
      xp_q <= x_i;
      yp_q <= y_o;
    end
  end

endmodule

// File: rtl/jtopl_snd_fifo.sv
// Captures accumulator samples on the sample boundary and buffers them for the mixer.
// Define JTOPL_SND_DCBLOCK_EN to insert the DC blocker ahead of the FIFO.
module jtopl_snd_fifo
  import jtopl_snd_pkg::*;
#(
  parameter int OUTW  = OUTW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int DCK   = DCK_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cenop,
  input  logic                   zero,
  input  logic signed [OUTW-1:0] snd,
  jtopl_snd_fifo_if.master       dout_if,
  output logic [AW:0]            level,
  output logic [DROPW-1:0]       drop_cnt,
  input  logic                   drop_clr
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("jtopl_snd_fifo: DEPTH must be a power of two >= 2 and equal 2**AW");
  end
  if (DCK < 1 || DCK >= OUTW) begin : g_bad_dck
    $error("jtopl_snd_fifo: DCK must lie in 1..OUTW-1");
  end

  logic                   cap_q;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            level_q, level_d;
  logic [AW:0]            arr_cnt;
  logic signed [OUTW-1:0] dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic [DROPW-1:0]       drop_q, drop_d;
  logic signed [OUTW-1:0] wdata;
  logic [OUTW-1:0]        mem_q [DEPTH];
  logic                   pop, wr_en, out_load;

`ifdef JTOPL_SND_DCBLOCK_EN
  jtopl_snd_dcblk #(
    .OUTW (OUTW),
    .DCK  (DCK)
  ) u_dcblk (
    .clk   (clk),
    .rst_n (rst_n),
    .cap_i (cap_q),
    .x_i   (snd),
    .y_o   (wdata)
  );
`else
  assign wdata = snd;
`endif

  assign pop      = dout_valid_q && dout_if.dout_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the sample.
  assign wr_en    = cap_q && ((level_q != LVL_FULL) || pop);
  assign arr_cnt  = level_q - (AW+1)'(dout_valid_q);
  assign out_load = (!dout_valid_q || pop) && (arr_cnt != '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    drop_d       = drop_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (out_load) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      dout_d       = mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
    end else if (pop) begin
      dout_valid_d = 1'b0;
    end

    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (drop_clr) begin
      drop_d = '0;
    end else if (cap_q && !wr_en && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      cap_q        <= cenop && zero;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign dout_if.dout       = dout_q;
  assign dout_if.dout_valid = dout_valid_q;
  assign level              = level_q;
  assign drop_cnt           = drop_q;

endmodule

// File: doc/jtopl_snd_fifo.md
Name: jtopl_snd_fifo

Overview:
- Downstream neighbour of the single-channel saturating accumulator.
- Captures each finished accumulated sample on the sample-boundary strobe and buffers it in a small FIFO.
- Presents samples to the audio mixer / DAC interface over a valid/ready handshake, decoupling the mixer from the operator time-slot schedule.
- Tracks dropped samples when the consumer stalls.

Parameters:
- OUTW, 16, sample width (two's complement), equal to the accumulator output width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, 2, address width = log2(DEPTH).
- DCK, 8, DC-blocker pole shift K; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cenop  in  1  operator clock enable; same enable that drives the accumulator.
- zero  in  1  sample-boundary strobe; same signal that restarts the accumulator.
- snd  in  OUTW  accumulator output, signed.
- dout  out  OUTW  head-of-FIFO sample, signed.
- dout_valid  out  1  dout holds a valid sample.
- dout_ready  in  1  consumer accepts dout this cycle.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- drop_cnt  out  8  saturating count of samples dropped while full.
- drop_clr  in  1  synchronous clear of drop_cnt.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - dout=0, dout_valid=0, level=0, drop_cnt=0;
  - read/write pointers, the capture strobe and the DC state.
- Capture:
  - snd is updated by the upstream block on the edge where cenop&&zero=1.
  - This block registers cap=cenop&&zero on that same edge.
  - On the next clk edge (cap=1) it samples snd, which is now stable, into the write path.
  - Capture latency: snd stable → written to FIFO in 1 clk. Written → dout_valid=1 one clk after the write (registered output).
  - A cap on the very first boundary after reset is still written; the value is 0.
- FIFO:
  - Write when cap=1 and level<DEPTH.
  - Read (pop) when dout_valid&&dout_ready.
  - Pointers are AW bits and wrap modulo DEPTH.
  - level is +1 on write-only, −1 on read-only, unchanged on simultaneous read and write.
  - Full with simultaneous pop and cap: the write is accepted, no drop, level stays DEPTH.
  - Full without pop: the sample is discarded and drop_cnt increments, saturating at 255.
  - drop_clr has priority over an increment in the same cycle; the result is 0.
  - Empty: dout_valid=0 and dout holds its last value. A pop request while empty is ignored.
  - Empty with a write in the same cycle: the sample appears on dout with dout_valid=1 on the following edge; there is no bypass path.
- Output register:
  - dout/dout_valid are loaded from the FIFO head whenever the output is empty, or is being popped and the FIFO is non-empty.
  - Otherwise they hold; dout must not change while dout_valid&&!dout_ready.
  - level counts entries in both the array and the output register, so its maximum is DEPTH total.
- cenop low: cap cannot assert. The handshake and output side run every clk regardless of cenop.

Optional Feature:
- JTOPL_SND_DCBLOCK_EN defined: each captured sample x passes through a one-pole DC blocker before the FIFO.
  - y = x − x_prev + y_prev − (y_prev >>> DCK).
  - Computed in OUTW+2 bits and saturated to OUTW: clip to 0x7FFF / 0x8000 for OUTW=16.
  - x_prev and y_prev update only on cap; both reset to 0.
  - Adds no latency; combinational in the capture cycle.
- Undefined: x is written unmodified and the DCK parameter is unused.

Decomposition:
- Shared package jtopl_snd_pkg holds:
  - localparams for the OUTW defaults and the drop counter width (8);
  - the saturation limit constants PLUS_INF/MINUS_INF, also used by the accumulator.
- Natural sub-module: jtopl_snd_dcblk, containing the filter state and saturation.
  - Instantiated only under JTOPL_SND_DCBLOCK_EN; otherwise replaced by a wire.
- FIFO storage and pointers stay inline.

Test Plan:
- Basic flow: cenop every 4th clk, zero pulse with snd=0x1234, dout_ready=1 → dout=0x1234 with dout_valid=1 exactly 2 clk after cap; level returns to 0.
- Fill/drop: dout_ready=0, 6 zero pulses with snd=1..6 → level=4, drop_cnt=2. Then raise ready → dout sequence is 1,2,3,4, and dout is held stable while stalled.
- Full + simultaneous pop: FIFO full, cap and pop in the same cycle → level stays 4, drop_cnt unchanged, order preserved.
- Drop saturation and clear: 300 drops → drop_cnt=255. drop_clr coincident with a drop → drop_cnt=0.
- Async reset mid-stream: assert rst_n low between clk edges with 3 entries held → outputs clear immediately; after release the next sample 0x0ABC emerges first.
- DC block (macro on, DCK=8): constant snd=0x4000 for 2000 samples → first output 0x4000, decaying monotonically toward 0 with |dout|<0x0100 by sample 2000. Step to 0x8000 from 0x7FFF → saturates at 0x8000, no wrap.
